// File: rtl/dac_dem_pkg.sv
// Shared constants and helpers for the 6-element DWA scheduler.
package dac_dem_pkg;

    localparam int unsigned N_ELEM     = 6;
    localparam int unsigned PTR_W      = 3;
    localparam int unsigned CODE_MAX   = 6;
    localparam int unsigned CLAMP_ZERO = 0;
    localparam int unsigned CLAMP_FULL = 1;

    // Out-of-range code 7 maps to either no elements or all elements.
    function automatic logic [2:0] code_to_k(input logic [2:0] code, input int unsigned clamp);
        if (code > 3'(CODE_MAX)) begin
            return (clamp == CLAMP_FULL) ? 3'(CODE_MAX) : 3'd0;
        end
        return code;
    endfunction

endpackage

// File: rtl/dwa_rot6.sv
// Combinational rotation: enables k consecutive elements starting at ptr (mod 6).
module dwa_rot6
    import dac_dem_pkg::*;
(
    input  logic [2:0]        k,
    input  logic [PTR_W-1:0]  ptr,
    output logic [N_ELEM-1:0] mask
);

    logic [3:0] off;

    always_comb begin
        mask = '0;
        off  = '0;
        for (int unsigned e = 0; e < N_ELEM; e++) begin
            // Distance of element e past the pointer, wrapped into 0..5.
            off = 4'(e) + 4'(N_ELEM) - {1'b0, ptr};
            if (off >= 4'(N_ELEM)) begin
                off = off - 4'(N_ELEM);
            end
            if (off < {1'b0, k}) begin
                mask[N_ELEM-1-e] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dwa_scheduler6.sv
// DWA unit-element scheduler: rotating or thermometer element selection with sticky code error.
module dwa_scheduler6
    import dac_dem_pkg::*;
#(
    parameter int unsigned CLAMP = CLAMP_ZERO
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [2:0]        code,
    input  logic              dem_en,
    input  logic              err_clr,
    output logic              out_valid,
    output logic [N_ELEM-1:0] elem,
    output logic [PTR_W-1:0]  ptr,
    output logic              code_err
);

    logic [N_ELEM-1:0] elem_q, elem_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic              code_err_q, code_err_d;

    logic [2:0]        k;
    logic [PTR_W-1:0]  rot_ptr;
    logic [N_ELEM-1:0] mask;
    logic [3:0]        ptr_sum;

    // Thermometer mode is the rotation with the pointer pinned at element 0.
    assign k       = code_to_k(code, CLAMP);
    assign rot_ptr = dem_en ? ptr_q : '0;

    dwa_rot6 u_rot (
        .k   (k),
        .ptr (rot_ptr),
        .mask(mask)
    );

    always_comb begin
        ptr_sum = {1'b0, ptr_q} + {1'b0, k};
        if (ptr_sum >= 4'(N_ELEM)) begin
            ptr_sum = ptr_sum - 4'(N_ELEM);
        end

        elem_d      = elem_q;
        ptr_d       = ptr_q;
        out_valid_d = in_valid;
        code_err_d  = code_err_q & ~err_clr;

        if (in_valid) begin
            elem_d = mask;
            ptr_d  = dem_en ? ptr_sum[PTR_W-1:0] : '0;
            if (code == 3'd7) begin
                code_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            elem_q      <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            code_err_q  <= 1'b0;
        end else begin
            elem_q      <= elem_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            code_err_q  <= code_err_d;
        end
    end

    assign elem      = elem_q;
    assign ptr       = ptr_q;
    assign out_valid = out_valid_q;
    assign code_err  = code_err_q;

endmodule

// File: tb/tb_dwa_scheduler6.sv
// Bench for dwa_scheduler6: both CLAMP settings against an arithmetic reference model.
module tb_dwa_scheduler6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] code = '0;
    logic       dem_en = 1'b0;
    logic       err_clr = 1'b0;

    logic       ov0, ov1, err0, err1;
    logic [5:0] elem0, elem1;
    logic [2:0] ptr0, ptr1;

    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [5:0] m_elem [2];
    int         m_ptr  [2];
    logic       m_err  [2];
    logic       m_ov;

    always #5 clk = ~clk;

    dwa_scheduler6 #(.CLAMP(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .code(code), .dem_en(dem_en),
        .err_clr(err_clr), .out_valid(ov0), .elem(elem0), .ptr(ptr0), .code_err(err0)
    );

    dwa_scheduler6 #(.CLAMP(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .code(code), .dem_en(dem_en),
        .err_clr(err_clr), .out_valid(ov1), .elem(elem1), .ptr(ptr1), .code_err(err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: element (base+i) mod 6 for i<k is on; element e sits at bit 5-e.
    task automatic model_step(input logic r, input logic v, input int c, input logic dem, input logic clr);
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                m_elem[d] = '0;
                m_ptr[d]  = 0;
                m_err[d]  = 1'b0;
            end else begin
                if (clr) m_err[d] = 1'b0;
                if (v) begin
                    int k;
                    int base;
                    k    = (c <= 6) ? c : ((d == 1) ? 6 : 0);
                    base = dem ? m_ptr[d] : 0;
                    if (c == 7) m_err[d] = 1'b1;
                    m_elem[d] = '0;
                    for (int i = 0; i < k; i++) m_elem[d][5 - ((base + i) % 6)] = 1'b1;
                    m_ptr[d] = dem ? (m_ptr[d] + k) % 6 : 0;
                end
            end
        end
        m_ov = r ? 1'b0 : v;
    endtask

    task automatic cycle(input logic r, input logic v, input int c, input logic dem, input logic clr);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        code     = 3'(c);
        dem_en   = dem;
        err_clr  = clr;
        @(posedge clk);
        model_step(r, v, c, dem, clr);
        #1;
        check("elem0", 32'(elem0), 32'(m_elem[0]));
        check("ptr0",  32'(ptr0),  32'(m_ptr[0]));
        check("err0",  32'(err0),  32'(m_err[0]));
        check("ov0",   32'(ov0),   32'(m_ov));
        check("elem1", 32'(elem1), 32'(m_elem[1]));
        check("ptr1",  32'(ptr1),  32'(m_ptr[1]));
        check("err1",  32'(err1),  32'(m_err[1]));
        check("ov1",   32'(ov1),   32'(m_ov));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_elem[d] = '0;
            m_ptr[d]  = 0;
            m_err[d]  = 1'b0;
        end
        m_ov = 1'b0;

        cycle(1, 0, 0, 1, 0);
        check("rst_elem", 32'(elem0), 32'h0);
        check("rst_ptr",  32'(ptr0),  32'h0);

        // Rotation sequence 2,3,4.
        cycle(0, 1, 2, 1, 0);
        check("rot_e2", 32'(elem0), 32'b110000);
        check("rot_p2", 32'(ptr0), 32'd2);
        cycle(0, 1, 3, 1, 0);
        check("rot_e3", 32'(elem0), 32'b001110);
        check("rot_p3", 32'(ptr0), 32'd5);
        cycle(0, 1, 4, 1, 0);
        check("rot_e4", 32'(elem0), 32'b111001);
        check("rot_p4", 32'(ptr0), 32'd3);

        // k=6 and k=0 boundaries at ptr=3.
        cycle(0, 1, 6, 1, 0);
        check("k6_elem", 32'(elem0), 32'b111111);
        check("k6_ptr",  32'(ptr0),  32'd3);
        cycle(0, 1, 0, 1, 0);
        check("k0_elem", 32'(elem0), 32'b000000);
        check("k0_ptr",  32'(ptr0),  32'd3);

        // Code 7 under both clamp settings, then set-wins against err_clr.
        cycle(0, 1, 7, 1, 0);
        check("c7_elem0", 32'(elem0), 32'b000000);
        check("c7_err0",  32'(err0),  32'd1);
        check("c7_ptr0",  32'(ptr0),  32'd3);
        check("c7_elem1", 32'(elem1), 32'b111111);
        check("c7_err1",  32'(err1),  32'd1);
        cycle(0, 1, 7, 1, 1);
        check("c7_setwins", 32'(err0), 32'd1);
        cycle(0, 0, 0, 1, 1);
        check("errclr", 32'(err0), 32'd0);

        // Bypass from ptr=4, then idle gap.
        cycle(0, 1, 1, 1, 0);
        check("byp_pre_ptr", 32'(ptr0), 32'd4);
        cycle(0, 1, 3, 0, 0);
        check("byp_elem", 32'(elem0), 32'b111000);
        check("byp_ptr",  32'(ptr0),  32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, $urandom_range(0, 7), 1, 0);
            check("gap_elem", 32'(elem0), 32'b111000);
            check("gap_ov",   32'(ov0),   32'd0);
        end

        // Reset in the middle of a valid stream.
        cycle(0, 1, 5, 1, 0);
        cycle(0, 1, 4, 1, 0);
        cycle(1, 1, 3, 1, 0);
        check("mid_rst_elem", 32'(elem0), 32'h0);
        check("mid_rst_ptr",  32'(ptr0),  32'h0);
        check("mid_rst_ov",   32'(ov0),   32'h0);
        cycle(0, 1, 1, 1, 0);
        check("post_rst_elem", 32'(elem0), 32'b100000);
        check("post_rst_ptr",  32'(ptr0),  32'd1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < 7),
                  $urandom_range(0, 7),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dwa_scheduler6.md
DWA_SCHEDULER6 -- requirements
Module: dwa_scheduler6

Interface
REQ-001 The block SHALL have parameter CLAMP, default 0: selects handling of out-of-range code 7 (0 -> zero elements, 1 -> all six elements).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a new sample is present on code this cycle.
REQ-005 The block SHALL have port code, input, 3 bits: requested number of active unit elements, legal range 0..6.
REQ-006 The block SHALL have port dem_en, input, 1 bit: 1 selects data-weighted-averaging rotation; 0 selects plain thermometer.
REQ-007 The block SHALL have port err_clr, input, 1 bit: clears code_err.
REQ-008 The block SHALL have port out_valid, output, 1 bit: elem was updated on the previous edge.
REQ-009 The block SHALL have port elem, output, 6 bits: unit-element enables; element e drives bit (5-e).
REQ-010 The block SHALL have port ptr, output, 3 bits: current rotation pointer, range 0..5.
REQ-011 The block SHALL have port code_err, output, 1 bit: sticky flag, set when code 7 was received.

Function
REQ-012 The block SHALL derive the element count k on each accepted sample: k = code for code 0..6; k = 0 for code 7 when CLAMP=0; k = 6 when CLAMP=1.
REQ-013 The block SHALL accept a sample only on a cycle with in_valid=1; it has no back-pressure.
REQ-014 The block SHALL register elem one cycle after acceptance; out_valid SHALL equal in_valid delayed by one cycle.
REQ-015 With dem_en=1, the block SHALL enable elements ptr, ptr+1, ..., ptr+k-1, each taken mod 6; all other elements SHALL be 0.
REQ-016 With dem_en=1, the block SHALL update ptr on acceptance to (ptr+k) mod 6.
- Computation uses a 4-bit sum (max 5+6=11) with a single conditional subtract of 6.
REQ-017 With dem_en=0, the block SHALL output elements 0..k-1 (plain thermometer: 1 -> 100000, 6 -> 111111) and SHALL force ptr to 0 on acceptance.
REQ-018 k=0 SHALL produce elem=000000 and leave ptr unchanged; k=6 SHALL produce elem=111111 and leave ptr unchanged.
REQ-019 On cycles with in_valid=0, elem and ptr SHALL hold their values and out_valid SHALL be 0.
REQ-020 A change of dem_en SHALL take effect on the next accepted sample; no intermediate output is produced.
REQ-021 The block SHALL set code_err on acceptance of code 7 regardless of CLAMP; the flag SHALL stay set until err_clr=1.
REQ-022 If err_clr and a new code-7 acceptance occur on the same cycle, code_err SHALL remain 1 (set wins).

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL set elem=000000, out_valid=0, ptr=0 and code_err=0, and SHALL discard in_valid that cycle.
REQ-024 On reset asserted mid-stream, the block SHALL restart rotation from ptr=0 with the first accepted sample after deassertion.

Structure
REQ-025 Package dac_dem_pkg SHALL hold N_ELEM=6, PTR_W=3, CODE_MAX=6 and the CLAMP encoding constants.
REQ-026 The rotation SHALL be a combinational sub-module dwa_rot6 (inputs k and ptr, output the 6-bit mask); the pointer, output registers and error flag SHALL stay in dwa_scheduler6.

Verification
REQ-027 The bench SHALL cover this rotation sequence: reset, dem_en=1, codes 2,3,4 on consecutive cycles -> elem 110000, 001110, 111001; ptr 2, 5, 3.
REQ-028 The bench SHALL cover the k=6 and k=0 boundaries: at ptr=3, code 6 -> elem 111111, ptr 3; then code 0 -> elem 000000, ptr 3.
REQ-029 The bench SHALL cover code 7 and error clearing:
- CLAMP=0, code 7 -> elem 000000, code_err=1, ptr unchanged.
- CLAMP=1, code 7 -> elem 111111.
- err_clr with simultaneous code 7 -> code_err stays 1.
REQ-030 The bench SHALL cover bypass: ptr=4, dem_en=0, code 3 -> elem 111000, ptr 0; a gap of 3 cycles with in_valid=0 -> elem held, out_valid 0.
REQ-031 The bench SHALL cover reset mid-stream: rst=1 for one cycle during continuous valid codes -> all outputs cleared next cycle; then code 1 -> elem 100000, ptr 1.
